// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: next-PC source codes
// (also used by the control unit) and a width helper.
package pc_unit_pkg;

  localparam logic [2:0] PCSRC_SEQ    = 3'd0;
  localparam logic [2:0] PCSRC_REL    = 3'd1;
  localparam logic [2:0] PCSRC_ABS    = 3'd2;
  localparam logic [2:0] PCSRC_RET    = 3'd3;
  localparam logic [2:0] PCSRC_REG    = 3'd4;
  localparam logic [2:0] PCSRC_REGREL = 3'd5;
  localparam logic [2:0] PCSRC_TRAP   = 3'd6;
  localparam logic [2:0] PCSRC_RSVD   = 3'd7;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/pc_unit_ras.sv
// Circular return-address stack: push, pop, or replace-top in one cycle, with
// a saturating entry count and sticky overflow/underflow flags.
module ras_stack
  import pc_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       pushData,
  output logic [WIDTH-1:0]       topData,
  output logic [clog2(DEPTH):0]  count,
  output logic                   empty,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W = clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] entries [DEPTH];
  logic [PTR_W-1:0] topPtr;
  logic             full;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign topData = entries[topPtr];

  // A push into a full stack just advances the pointer, so the oldest entry
  // is the one overwritten; a pop from empty leaves everything but the flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      topPtr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (pop && empty) underflow <= 1'b1;
      if (push && !pop) begin
        topPtr <= topPtr + PTR_W'(1);
        if (full) overflow <= 1'b1;
        else      count    <= count + 1'b1;
      end else if (pop && !push && !empty) begin
        topPtr <= topPtr - PTR_W'(1);
        count  <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (push && !pop)               entries[topPtr + PTR_W'(1)] <= pushData;
      else if (push && pop && !empty) entries[topPtr]             <= pushData;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with eight-way next-PC select, condition gating and a
// hardware return-address stack for call/return.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              WIDTH        = 16,
  parameter int              INC          = 2,
  parameter int              RAS_DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 16'h0000,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = 16'h0010
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      pcWrite,
  input  logic [2:0]                pcSrc,
  input  logic                      condEn,
  input  logic                      cond,
  input  logic [WIDTH-1:0]          offset,
  input  logic [WIDTH-1:0]          absAddr,
  input  logic [WIDTH-1:0]          regVal,
  input  logic                      call,
  output logic [WIDTH-1:0]          pcCur,
  output logic [WIDTH-1:0]          pcNext,
  output logic                      taken,
  output logic [clog2(RAS_DEPTH):0] rasCount,
  output logic                      rasOverflow,
  output logic                      rasUnderflow
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  logic [WIDTH-1:0] seqPc;
  logic [WIDTH-1:0] rasTop;
  logic             rasEmpty;
  logic             gateOpen;
  logic             push;
  logic             pop;

  assign seqPc    = pcCur + INC_W;
  assign gateOpen = !condEn || cond;
  assign push     = pcWrite && call &&
                    (taken || pcSrc == PCSRC_SEQ || pcSrc == PCSRC_RSVD);
  assign pop      = pcWrite && taken && (pcSrc == PCSRC_RET);

  // A closed condition gate forces the sequential path regardless of source.
  always_comb begin
    pcNext = seqPc;
    taken  = 1'b0;
    if (gateOpen) begin
      case (pcSrc)
        PCSRC_REL:    begin pcNext = pcCur + offset;  taken = 1'b1; end
        PCSRC_ABS:    begin pcNext = absAddr;         taken = 1'b1; end
        PCSRC_RET:    begin pcNext = rasEmpty ? TRAP_VECTOR : rasTop; taken = 1'b1; end
        PCSRC_REG:    begin pcNext = regVal;          taken = 1'b1; end
        PCSRC_REGREL: begin pcNext = pcCur + regVal;  taken = 1'b1; end
        PCSRC_TRAP:   begin pcNext = TRAP_VECTOR;     taken = 1'b1; end
        default:      begin pcNext = seqPc;           taken = 1'b0; end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset)        pcCur <= RESET_VECTOR;
    else if (pcWrite) pcCur <= pcNext;
  end

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .pushData  (seqPc),
    .topData   (rasTop),
    .count     (rasCount),
    .empty     (rasEmpty),
    .overflow  (rasOverflow),
    .underflow (rasUnderflow)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed walk with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_pc_unit;
  import pc_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        pcWrite;
  logic [2:0]  pcSrc;
  logic        condEn;
  logic        cond;
  logic [15:0] offset;
  logic [15:0] absAddr;
  logic [15:0] regVal;
  logic        call;
  logic [15:0] pcCur;
  logic [15:0] pcNext;
  logic        taken;
  logic [2:0]  rasCount;
  logic        rasOverflow;
  logic        rasUnderflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] mPc;
  logic [15:0] mRas[$];
  bit          mOver;
  bit          mUnder;
  bit          modelValid = 1'b0;

  pc_unit #(
    .WIDTH        (16),
    .INC          (2),
    .RAS_DEPTH    (4),
    .RESET_VECTOR (16'h0000),
    .TRAP_VECTOR  (16'h0010)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pcWrite      (pcWrite),
    .pcSrc        (pcSrc),
    .condEn       (condEn),
    .cond         (cond),
    .offset       (offset),
    .absAddr      (absAddr),
    .regVal       (regVal),
    .call         (call),
    .pcCur        (pcCur),
    .pcNext       (pcNext),
    .taken        (taken),
    .rasCount     (rasCount),
    .rasOverflow  (rasOverflow),
    .rasUnderflow (rasUnderflow)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // What the next PC must be, straight from the source table and gate rule.
  function automatic void modelNext(output logic [15:0] nxt, output bit tk);
    nxt = mPc + 16'd2;
    tk  = 1'b0;
    if (!(condEn && !cond)) begin
      case (pcSrc)
        3'd1: begin nxt = mPc + offset; tk = 1'b1; end
        3'd2: begin nxt = absAddr;      tk = 1'b1; end
        3'd3: begin nxt = (mRas.size() > 0) ? mRas[$] : 16'h0010; tk = 1'b1; end
        3'd4: begin nxt = regVal;       tk = 1'b1; end
        3'd5: begin nxt = mPc + regVal; tk = 1'b1; end
        3'd6: begin nxt = 16'h0010;     tk = 1'b1; end
        default: ;
      endcase
    end
  endfunction

  always @(posedge clock) begin
    logic [15:0] nxt;
    bit          tk;
    bit          doPush;
    bit          doPop;
    if (reset) begin
      mPc        = 16'h0000;
      mRas.delete();
      mOver      = 1'b0;
      mUnder     = 1'b0;
      modelValid = 1'b1;
    end else if (modelValid && pcWrite) begin
      modelNext(nxt, tk);
      doPush = call && (tk || pcSrc == 3'd0 || pcSrc == 3'd7);
      doPop  = tk && pcSrc == 3'd3;
      if (doPop && mRas.size() == 0) begin
        mUnder = 1'b1;
      end else if (doPop && doPush) begin
        mRas[mRas.size() - 1] = mPc + 16'd2;
      end else if (doPop) begin
        void'(mRas.pop_back());
      end else if (doPush) begin
        if (mRas.size() == 4) begin
          void'(mRas.pop_front());
          mOver = 1'b1;
        end
        mRas.push_back(mPc + 16'd2);
      end
      mPc = nxt;
    end
  end

  always @(negedge clock) begin
    logic [15:0] nxt;
    bit          tk;
    if (modelValid) begin
      modelNext(nxt, tk);
      checkOutput("pcCur",        pcCur,                  mPc);
      checkOutput("pcNext",       pcNext,                 nxt);
      checkOutput("taken",        {15'd0, taken},         {15'd0, tk});
      checkOutput("rasCount",     {13'd0, rasCount},      16'(mRas.size()));
      checkOutput("rasOverflow",  {15'd0, rasOverflow},   {15'd0, mOver});
      checkOutput("rasUnderflow", {15'd0, rasUnderflow},  {15'd0, mUnder});
    end
  end

  task automatic applyStimulus(input bit w, input logic [2:0] src, input bit ce,
                               input bit c, input logic [15:0] off,
                               input logic [15:0] abs, input logic [15:0] rv,
                               input bit cl);
    pcWrite = w;
    pcSrc   = src;
    condEn  = ce;
    cond    = c;
    offset  = off;
    absAddr = abs;
    regVal  = rv;
    call    = cl;
    #1;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic jumpTo(input logic [15:0] target, input bit cl);
    applyStimulus(1, PCSRC_ABS, 0, 0, 16'h0, target, 16'h0, cl);
    tick();
  endtask

  task automatic doRet(input logic [15:0] expected, input string name);
    applyStimulus(1, PCSRC_RET, 0, 0, 16'h0, 16'h0, 16'h0, 0);
    checkOutput({name, "_pcNext"}, pcNext, expected);
    tick();
    checkOutput(name, pcCur, expected);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, PCSRC_SEQ, 0, 0, 16'h0, 16'h0, 16'h0, 0);
    tick();
    tick();
    checkOutput("resetPc",    pcCur, 16'h0000);
    checkOutput("resetCount", {13'd0, rasCount}, 16'd0);
    reset = 1'b0;

    applyStimulus(1, PCSRC_SEQ, 0, 0, 16'h0, 16'h0, 16'h0, 0);
    tick(); checkOutput("seq1", pcCur, 16'h0002);
    tick(); checkOutput("seq2", pcCur, 16'h0004);
    tick(); checkOutput("seq3", pcCur, 16'h0006);

    jumpTo(16'h0004, 0);
    applyStimulus(1, PCSRC_REL, 0, 0, 16'hFFFC, 16'h0, 16'h0, 0);
    checkOutput("relTaken", {15'd0, taken}, 16'd1);
    tick(); checkOutput("relBack", pcCur, 16'h0000);
    jumpTo(16'h0004, 0);
    applyStimulus(1, PCSRC_REL, 1, 0, 16'hFFFC, 16'h0, 16'h0, 0);
    checkOutput("gatedTaken", {15'd0, taken}, 16'd0);
    tick(); checkOutput("gatedPc", pcCur, 16'h0006);

    jumpTo(16'h0010, 0);
    jumpTo(16'h0200, 1);
    checkOutput("callPc",    pcCur, 16'h0200);
    checkOutput("callCount", {13'd0, rasCount}, 16'd1);
    doRet(16'h0012, "retPc");
    checkOutput("retCount", {13'd0, rasCount}, 16'd0);

    jumpTo(16'h0010, 0);
    jumpTo(16'h0020, 1);
    jumpTo(16'h0030, 1);
    jumpTo(16'h0040, 1);
    jumpTo(16'h0050, 1);
    jumpTo(16'h0100, 1);
    checkOutput("ovfFlag",  {15'd0, rasOverflow}, 16'd1);
    checkOutput("ovfCount", {13'd0, rasCount}, 16'd4);
    doRet(16'h0052, "ret1");
    doRet(16'h0042, "ret2");
    doRet(16'h0032, "ret3");
    doRet(16'h0022, "ret4");
    doRet(16'h0010, "retEmpty");
    checkOutput("udfFlag", {15'd0, rasUnderflow}, 16'd1);

    jumpTo(16'h0030, 1);
    applyStimulus(0, PCSRC_ABS, 0, 0, 16'h0, 16'h0400, 16'h0, 1);
    tick();
    checkOutput("stallPc",    pcCur, 16'h0030);
    checkOutput("stallCount", {13'd0, rasCount}, 16'd1);
    jumpTo(16'hFFFE, 0);
    applyStimulus(1, PCSRC_REGREL, 0, 0, 16'h0, 16'h0, 16'h0004, 0);
    tick(); checkOutput("regrelWrap", pcCur, 16'h0002);

    applyStimulus(1, PCSRC_ABS, 0, 0, 16'h0, 16'h0300, 16'h0, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rstCallPc",    pcCur, 16'h0000);
    checkOutput("rstCallCount", {13'd0, rasCount}, 16'd0);
    checkOutput("rstCallOvf",   {15'd0, rasOverflow}, 16'd0);
    checkOutput("rstCallUdf",   {15'd0, rasUnderflow}, 16'd0);

    // Randomized traffic; the negedge compare process does the checking.
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      applyStimulus($urandom_range(0, 9) < 8, 3'($urandom_range(0, 7)),
                    $urandom_range(0, 9) < 3, 1'($urandom),
                    16'($urandom), 16'($urandom), 16'($urandom),
                    $urandom_range(0, 9) < 3);
      tick();
    end
    reset = 1'b0;
    @(negedge clock);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
